// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: FSM states, requester ID,
// requester count, and the ALUSel codes pulled in from Riscv_defs.svh.
package alu_arb_pkg;
  `include "Riscv_defs.svh"

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef logic req_id_t;
  localparam int NUM_REQ = 2;
endpackage

// File: rtl/Riscv_defs.svh
// Shared RISC-V ALU operation select codes (ALUSel), included by any block that
// drives or decodes the ALU select field.
`ifndef RISCV_DEFS_SVH
`define RISCV_DEFS_SVH

localparam logic [4:0] ALUNoP  = 5'd0;
localparam logic [4:0] ALUadd  = 5'd1;
localparam logic [4:0] ALUsub  = 5'd2;
localparam logic [4:0] ALUand  = 5'd3;
localparam logic [4:0] ALUor   = 5'd4;
localparam logic [4:0] ALUxor  = 5'd5;
localparam logic [4:0] ALUsll  = 5'd6;
localparam logic [4:0] ALUsrl  = 5'd7;
localparam logic [4:0] ALUsra  = 5'd8;
localparam logic [4:0] ALUslt  = 5'd9;
localparam logic [4:0] ALUsltu = 5'd10;

`endif

// File: rtl/alu_arb_pick.sv
// Combinational grant picker: request vector + last grant -> one-hot grant.
// ALU_ARB_RR_EN selects round-robin on contention; otherwise requester 0 wins.
module alu_arb_pick
  import alu_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            last,
  output logic [NUM_REQ-1:0] gnt
);

`ifdef ALU_ARB_RR_EN
  always_comb begin
    gnt = '0;
    if (req[0] && req[1]) gnt = last ? 2'b01 : 2'b10;
    else                  gnt = req;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt = '0;
    gnt = req[0] ? 2'b01 : req;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: IDLE grants and latches an op,
// EXEC drives the ALU and captures its result, RESP holds it until consumed.
// Define ALU_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_0,
  output logic            req_ready_0,
  input  logic [XLEN-1:0] req_a_0,
  input  logic [XLEN-1:0] req_b_0,
  input  logic [4:0]      req_sel_0,
  input  logic            req_valid_1,
  output logic            req_ready_1,
  input  logic [XLEN-1:0] req_a_1,
  input  logic [XLEN-1:0] req_b_1,
  input  logic [4:0]      req_sel_1,
  output logic            rsp_valid_0,
  input  logic            rsp_ready_0,
  output logic [XLEN-1:0] rsp_result_0,
  output logic            rsp_zero_0,
  output logic            rsp_valid_1,
  input  logic            rsp_ready_1,
  output logic [XLEN-1:0] rsp_result_1,
  output logic            rsp_zero_1,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  state_t              state, state_nxt;
  req_id_t             gnt_id, last_gnt;
  logic [NUM_REQ-1:0]  req_vec, gnt;
  logic [XLEN-1:0]     a_q, b_q, res_q;
  logic [4:0]          sel_q;
  logic                zero_q;
  logic                accept, rsp_hs, resp_0, resp_1;

`ifdef ALU_ARB_RR_EN
  req_id_t last_q;
  always_ff @(posedge clk) begin
    if (rst)         last_q <= 1'b1;
    else if (accept) last_q <= req_id_t'(gnt[1]);
  end
  assign last_gnt = last_q;
`else
  assign last_gnt = 1'b1;
`endif

  assign req_vec = {req_valid_1, req_valid_0};

  alu_arb_pick u_pick (
    .req  (req_vec),
    .last (last_gnt),
    .gnt  (gnt)
  );

  // Ready is only offered in IDLE and never while reset is asserted.
  assign accept      = (state == IDLE) && !rst && (|gnt);
  assign req_ready_0 = accept && gnt[0];
  assign req_ready_1 = accept && gnt[1];

  // Only the granted requester's rsp_ready can complete the response.
  assign rsp_hs = gnt_id ? rsp_ready_1 : rsp_ready_0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|gnt) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= ALUNoP;
      gnt_id <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= gnt[1] ? req_a_1   : req_a_0;
        b_q    <= gnt[1] ? req_b_1   : req_b_0;
        sel_q  <= gnt[1] ? req_sel_1 : req_sel_0;
        gnt_id <= req_id_t'(gnt[1]);
      end
      if (state == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_a   = (state == EXEC) ? a_q   : '0;
  assign alu_b   = (state == EXEC) ? b_q   : '0;
  assign alu_sel = (state == EXEC) ? sel_q : ALUNoP;

  assign resp_0 = (state == RESP) && !rst && (gnt_id == 1'b0);
  assign resp_1 = (state == RESP) && !rst && (gnt_id == 1'b1);

  assign rsp_valid_0  = resp_0;
  assign rsp_result_0 = resp_0 ? res_q : '0;
  assign rsp_zero_0   = resp_0 && zero_q;
  assign rsp_valid_1  = resp_1;
  assign rsp_result_1 = resp_1 ? res_q : '0;
  assign rsp_zero_1   = resp_1 && zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, expected-response
// scoreboard queue, one task per scenario.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid_0 = 0, req_valid_1 = 0;
  logic            req_ready_0, req_ready_1;
  logic [XLEN-1:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
  logic [4:0]      req_sel_0 = '0, req_sel_1 = '0;
  logic            rsp_valid_0, rsp_valid_1;
  logic            rsp_ready_0 = 0, rsp_ready_1 = 0;
  logic [XLEN-1:0] rsp_result_0, rsp_result_1;
  logic            rsp_zero_0, rsp_zero_1;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [4:0]      alu_sel;
  logic            alu_zero;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_sel_0(req_sel_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_a_1(req_a_1), .req_b_1(req_b_1), .req_sel_1(req_sel_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
    .rsp_result_0(rsp_result_0), .rsp_zero_0(rsp_zero_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_result_1(rsp_result_1), .rsp_zero_1(rsp_zero_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Behavioural ALU on the far side of the arbiter; unknown selects return 0.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      ALUadd:  alu_result = alu_a + alu_b;
      ALUsub:  alu_result = alu_a - alu_b;
      ALUand:  alu_result = alu_a & alu_b;
      ALUor:   alu_result = alu_a | alu_b;
      ALUxor:  alu_result = alu_a ^ alu_b;
      ALUsll:  alu_result = alu_a << alu_b[4:0];
      ALUsrl:  alu_result = alu_a >> alu_b[4:0];
      ALUsra:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; req_valid_0 = 1'b1; req_a_0 = 32'd9; req_sel_0 = ALUadd;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++; if (req_ready_0 !== 1'b0) $display("FAIL rst_req_ready0: got %b want 0", req_ready_0); else pass_cnt++;
    total++; if (alu_sel !== ALUNoP) $display("FAIL rst_alu_sel: got %0d want %0d", alu_sel, ALUNoP); else pass_cnt++;
    total++; if (alu_a !== '0 || alu_b !== '0) $display("FAIL rst_alu_ab: got %h/%h want 0/0", alu_a, alu_b); else pass_cnt++;
    total++; if ({rsp_valid_0, rsp_valid_1} !== 2'b00) $display("FAIL rst_rsp_valid: got %b want 00", {rsp_valid_0, rsp_valid_1}); else pass_cnt++;
    total++; if (rsp_result_0 !== '0 || rsp_zero_0 !== 1'b0) $display("FAIL rst_rsp_result0: got %h/%b want 0/0", rsp_result_0, rsp_zero_0); else pass_cnt++;
    req_valid_0 = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready_0 !== 1'b0 || alu_sel !== ALUNoP) $display("FAIL post_rst_idle: got ready=%b sel=%0d want 0/0", req_ready_0, alu_sel); else pass_cnt++;
    tick();
    e.id = 0; e.res = 0; e.zero = 0;
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic test_single_req0();
    exp_t e;
    req_valid_0 = 1'b1; req_a_0 = 32'd5; req_b_0 = 32'd3; req_sel_0 = ALUadd; rsp_ready_0 = 1'b1;
    @(negedge clk);
    total++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) $display("FAIL add_grant: got %b%b want 01", req_ready_1, req_ready_0); else pass_cnt++;
    if (req_ready_0 === 1'b1) sb.push_back('{1'b0, 32'd8, 1'b0});
    tick();
    req_valid_0 = 1'b0; req_a_0 = 32'hdead_beef; req_sel_0 = ALUxor;
    @(negedge clk);
    total++; if (alu_sel !== ALUadd || alu_a !== 32'd5 || alu_b !== 32'd3) $display("FAIL add_exec: got sel=%0d a=%h b=%h want %0d/5/3", alu_sel, alu_a, alu_b, ALUadd); else pass_cnt++;
    total++; if (rsp_valid_0 !== 1'b0) $display("FAIL add_early_rsp: got %b want 0", rsp_valid_0); else pass_cnt++;
    tick();
    @(negedge clk);
    total++; if (rsp_valid_0 !== 1'b1) $display("FAIL add_rsp_valid: got %b want 1", rsp_valid_0); else pass_cnt++;
    if (rsp_valid_0 && rsp_ready_0) begin
      total++;
      if (sb.size() == 0) $display("FAIL add_sb: response with no expected entry");
      else begin
        e = sb.pop_front();
        if (e.id !== 1'b0 || rsp_result_0 !== e.res || rsp_zero_0 !== e.zero)
          $display("FAIL add_result: got id0 %h/%b want id%0d %h/%b", rsp_result_0, rsp_zero_0, e.id, e.res, e.zero);
        else pass_cnt++;
      end
    end
    tick();
    @(negedge clk);
    total++; if (rsp_valid_0 !== 1'b0) $display("FAIL add_rsp_drop: got %b want 0", rsp_valid_0); else pass_cnt++;
    tick();
  endtask

  task automatic test_hold_req1();
    exp_t e;
    req_valid_1 = 1'b1; req_a_1 = 32'd7; req_b_1 = 32'd7; req_sel_1 = ALUsub;
    rsp_ready_1 = 1'b0; rsp_ready_0 = 1'b1;
    @(negedge clk);
    total++; if (req_ready_1 !== 1'b1 || req_ready_0 !== 1'b0) $display("FAIL hold_grant: got %b%b want 10", req_ready_1, req_ready_0); else pass_cnt++;
    if (req_ready_1 === 1'b1) sb.push_back('{1'b1, 32'd0, 1'b1});
    tick();
    req_valid_1 = 1'b0;
    req_valid_0 = 1'b1; req_a_0 = 32'd1; req_b_0 = 32'd1; req_sel_0 = ALUadd;
    @(negedge clk);
    total++; if (req_ready_0 !== 1'b0) $display("FAIL hold_exec_ready: got %b want 0", req_ready_0); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      total++;
      if (rsp_valid_1 !== 1'b1 || rsp_result_1 !== 32'd0 || rsp_zero_1 !== 1'b1 || rsp_valid_0 !== 1'b0)
        $display("FAIL hold_rsp c%0d: got v1=%b r1=%h z1=%b v0=%b want 1/0/1/0", c, rsp_valid_1, rsp_result_1, rsp_zero_1, rsp_valid_0);
      else pass_cnt++;
      total++;
      if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) $display("FAIL hold_ready c%0d: got %b%b want 00", c, req_ready_1, req_ready_0);
      else pass_cnt++;
    end
    tick();
    rsp_ready_1 = 1'b1; req_valid_0 = 1'b0;
    @(negedge clk);
    total++;
    if (!(rsp_valid_1 && rsp_ready_1)) $display("FAIL hold_release: got v1=%b want 1", rsp_valid_1);
    else if (sb.size() == 0) $display("FAIL hold_sb: response with no expected entry");
    else begin
      e = sb.pop_front();
      if (e.id !== 1'b1 || rsp_result_1 !== e.res || rsp_zero_1 !== e.zero)
        $display("FAIL hold_result: got id1 %h/%b want id%0d %h/%b", rsp_result_1, rsp_zero_1, e.id, e.res, e.zero);
      else pass_cnt++;
    end
    tick();
    @(negedge clk);
    total++; if (rsp_valid_1 !== 1'b0 || req_ready_0 !== 1'b0) $display("FAIL hold_after: got v1=%b rdy0=%b want 0/0", rsp_valid_1, req_ready_0); else pass_cnt++;
    tick();
  endtask

  task automatic test_bad_sel();
    exp_t e;
    req_valid_1 = 1'b1; req_a_1 = 32'd3; req_b_1 = 32'd4; req_sel_1 = 5'd31; rsp_ready_1 = 1'b1;
    @(negedge clk);
    if (req_ready_1 === 1'b1) sb.push_back('{1'b1, 32'd0, 1'b1});
    tick();
    req_valid_1 = 1'b0;
    @(negedge clk);
    total++; if (alu_sel !== 5'd31) $display("FAIL badsel_pass: got %0d want 31", alu_sel); else pass_cnt++;
    tick();
    @(negedge clk);
    total++;
    if (!rsp_valid_1) $display("FAIL badsel_rsp: got v1=%b want 1", rsp_valid_1);
    else if (sb.size() == 0) $display("FAIL badsel_sb: response with no expected entry");
    else begin
      e = sb.pop_front();
      if (rsp_result_1 !== e.res || rsp_zero_1 !== e.zero)
        $display("FAIL badsel_result: got %h/%b want %h/%b", rsp_result_1, rsp_zero_1, e.res, e.zero);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_sra();
    exp_t e;
    req_valid_0 = 1'b1; req_a_0 = 32'h8000_0000; req_b_0 = 32'd4; req_sel_0 = ALUsra;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b1;
    @(negedge clk);
    total++; if (req_ready_0 !== 1'b1) $display("FAIL sra_grant: got %b want 1", req_ready_0); else pass_cnt++;
    if (req_ready_0 === 1'b1) sb.push_back('{1'b0, 32'hF800_0000, 1'b0});
    tick();
    req_valid_0 = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (rsp_valid_0 !== 1'b1 || rsp_valid_1 !== 1'b0 || rsp_result_1 !== '0)
      $display("FAIL sra_rsp: got v0=%b v1=%b r1=%h want 1/0/0", rsp_valid_0, rsp_valid_1, rsp_result_1);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total++; if (rsp_valid_0 !== 1'b1) $display("FAIL sra_ignore_rdy1: got v0=%b want 1", rsp_valid_0); else pass_cnt++;
    rsp_ready_0 = 1'b1;
    total++;
    if (sb.size() == 0) $display("FAIL sra_sb: response with no expected entry");
    else begin
      e = sb.pop_front();
      if (rsp_result_0 !== e.res || rsp_zero_0 !== e.zero)
        $display("FAIL sra_result: got %h/%b want %h/%b", rsp_result_0, rsp_zero_0, e.res, e.zero);
      else pass_cnt++;
    end
    tick();
    @(negedge clk);
    total++; if (rsp_valid_0 !== 1'b0) $display("FAIL sra_done: got %b want 0", rsp_valid_0); else pass_cnt++;
    tick();
  endtask

  task automatic test_contention();
    exp_t e;
    int   ng = 0;
    int   cycles = 0;
    int   prev = 0;
    logic exp_id;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid_0 = 1'b1; req_a_0 = 32'd100; req_b_0 = 32'd1; req_sel_0 = ALUadd;
    req_valid_1 = 1'b1; req_a_1 = 32'd50;  req_b_1 = 32'd8; req_sel_1 = ALUsub;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    while ((ng < 4 || sb.size() > 0) && cycles < 60) begin
      @(negedge clk);
      if (req_ready_0 || req_ready_1) begin
`ifdef ALU_ARB_RR_EN
        exp_id = (ng % 2 == 1);
`else
        exp_id = 1'b0;
`endif
        total++;
        if (req_ready_1 !== exp_id || req_ready_0 === req_ready_1)
          $display("FAIL rr_grant%0d: got %b%b want id %0d", ng, req_ready_1, req_ready_0, exp_id);
        else pass_cnt++;
        if (ng > 0) begin
          total++; if (cycles - prev != 3) $display("FAIL rr_interval%0d: got %0d want 3", ng, cycles - prev); else pass_cnt++;
        end
        prev = cycles;
        sb.push_back('{req_ready_1, req_ready_1 ? 32'd42 : 32'd101, 1'b0});
        ng++;
      end
      if (rsp_valid_0 || rsp_valid_1) begin
        total++;
        if (sb.size() == 0) $display("FAIL rr_sb: response with no expected entry");
        else begin
          e = sb.pop_front();
          if (rsp_valid_1 !== e.id || (rsp_valid_1 ? rsp_result_1 : rsp_result_0) !== e.res)
            $display("FAIL rr_result: got id%0d %h want id%0d %h", rsp_valid_1, rsp_valid_1 ? rsp_result_1 : rsp_result_0, e.id, e.res);
          else pass_cnt++;
        end
      end
      tick();
      cycles++;
      if (ng == 4) begin
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      end
    end
    total++;
    if (ng != 4 || sb.size() != 0) $display("FAIL rr_timeout: got grants=%0d pending=%0d want 4/0", ng, sb.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_exec();
    req_valid_0 = 1'b1; req_a_0 = 32'd1; req_b_0 = 32'd2; req_sel_0 = ALUadd; rsp_ready_0 = 1'b1;
    @(negedge clk);
    total++; if (req_ready_0 !== 1'b1) $display("FAIL rexec_grant: got %b want 1", req_ready_0); else pass_cnt++;
    tick();
    req_valid_0 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (alu_sel !== ALUNoP || rsp_valid_0 !== 1'b0) $display("FAIL rexec_flush: got sel=%0d v0=%b want 0/0", alu_sel, rsp_valid_0); else pass_cnt++;
    tick();
    @(negedge clk);
    total++; if (rsp_valid_0 !== 1'b0) $display("FAIL rexec_no_rsp: got %b want 0", rsp_valid_0); else pass_cnt++;
    tick();
    test_single_req0();
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_hold_req1();
    test_bad_sel();
    test_sra();
    test_contention();
    test_reset_exec();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
